// File: rtl/mem_arb_pkg.sv
// Shared encodings for the two-port unified-memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        WAIT   = 2'b10,
        RESP   = 2'b11
    } state_t;

    localparam logic REQ_CPU = 1'b0;
    localparam logic REQ_AUX = 1'b1;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way round-robin picker: on a tie the requester that did not
// win last time is chosen.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       valid,
    output logic       winner
);

    always_comb begin
        valid = |req;
        if (req == 2'b11) begin
            winner = ~last_grant;
        end else if (req[1]) begin
            winner = REQ_AUX;
        end else begin
            winner = REQ_CPU;
        end
    end

endmodule

// File: rtl/mem_arb2.sv
// Two-requester arbiter for the CPU's unified instruction/data memory.
// One transaction at a time: IDLE sample, one ACCESS strobe, MEM_LAT-1 WAIT cycles, one RESP ack.
module mem_arb2
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              grant,
    output logic              busy
);

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((MEM_LAT >= 2) ? (MEM_LAT - 2) : 0);

    state_t            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              busy_q, busy_d;

    logic              pick_valid;
    logic              pick_winner;

    rr_pick2 u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d      = pick_winner;
                    last_grant_d = pick_winner;
                    we_d         = pick_winner ? m1_we    : m0_we;
                    addr_d       = pick_winner ? m1_addr  : m0_addr;
                    wdata_d      = pick_winner ? m1_wdata : m0_wdata;
                    state_d      = ACCESS;
                end
            end
            ACCESS: begin
                if (MEM_LAT == 1) begin
                    state_d = RESP;
                end else begin
                    cnt_d   = WAIT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they come straight out of flops.
        busy_d   = (state_d != IDLE);
        mem_en_d = (state_d == ACCESS);
        mem_we_d = (state_d == ACCESS) && we_d;
        ack0_d   = (state_d == RESP) && (grant_d == REQ_CPU);
        ack1_d   = (state_d == RESP) && (grant_d == REQ_AUX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= REQ_CPU;
            last_grant_q <= REQ_AUX;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign m0_ack    = ack0_q;
    assign m1_ack    = ack1_q;
    assign m0_rdata  = ack0_q ? mem_rdata : '0;
    assign m1_rdata  = ack1_q ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arb2.sv
// Directed bench for mem_arb2: three instances (MEM_LAT 1, 3, 4) each with a
// behavioural synchronous memory.
module tb_mem_arb2;

    localparam int N = 3;
    localparam int LATS [N] = '{1, 3, 4};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst       [N];
    logic        m0_req    [N];
    logic        m0_we     [N];
    logic [9:0]  m0_addr   [N];
    logic [31:0] m0_wdata  [N];
    logic        m0_ack    [N];
    logic [31:0] m0_rdata  [N];
    logic        m1_req    [N];
    logic        m1_we     [N];
    logic [9:0]  m1_addr   [N];
    logic [31:0] m1_wdata  [N];
    logic        m1_ack    [N];
    logic [31:0] m1_rdata  [N];
    logic        mem_en    [N];
    logic        mem_we    [N];
    logic [9:0]  mem_addr  [N];
    logic [31:0] mem_wdata [N];
    logic [31:0] mem_rdata [N];
    logic        grant     [N];
    logic        busy      [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_inst
        logic [31:0] mem  [0:1023];
        logic [31:0] pipe [0:3];

        mem_arb2 #(
            .ADDR_W  (10),
            .DATA_W  (32),
            .MEM_LAT (LATS[gi])
        ) u_dut (
            .clk       (clk),
            .rst       (rst[gi]),
            .m0_req    (m0_req[gi]),
            .m0_we     (m0_we[gi]),
            .m0_addr   (m0_addr[gi]),
            .m0_wdata  (m0_wdata[gi]),
            .m0_ack    (m0_ack[gi]),
            .m0_rdata  (m0_rdata[gi]),
            .m1_req    (m1_req[gi]),
            .m1_we     (m1_we[gi]),
            .m1_addr   (m1_addr[gi]),
            .m1_wdata  (m1_wdata[gi]),
            .m1_ack    (m1_ack[gi]),
            .m1_rdata  (m1_rdata[gi]),
            .mem_en    (mem_en[gi]),
            .mem_we    (mem_we[gi]),
            .mem_addr  (mem_addr[gi]),
            .mem_wdata (mem_wdata[gi]),
            .mem_rdata (mem_rdata[gi]),
            .grant     (grant[gi]),
            .busy      (busy[gi])
        );

        // Word a holds 0xA0000000|a, except word 4 holds an instruction pattern.
        initial begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA000_0000 | 32'(i);
            mem[4] <= 32'h2008_0005;
            for (int i = 0; i < 4; i++) pipe[i] <= '0;
        end

        always @(posedge clk) begin
            if (mem_en[gi]) begin
                pipe[0] <= mem[mem_addr[gi]];
                if (mem_we[gi]) mem[mem_addr[gi]] <= mem_wdata[gi];
            end
            for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
        end

        assign mem_rdata[gi] = pipe[LATS[gi]-1];
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction and wait (bounded) for its ack.
    task automatic txn(input int k, input int p, input logic we, input logic [9:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd, input int exp_lat,
                       input string tag);
        int          lat;
        int          en_n;
        int          we_n;
        int          oth_n;
        logic [31:0] rd;
        lat = 0; en_n = 0; we_n = 0; oth_n = 0; rd = '0;
        if (p == 0) begin
            m0_req[k] = 1'b1; m0_we[k] = we; m0_addr[k] = a; m0_wdata[k] = wd;
        end else begin
            m1_req[k] = 1'b1; m1_we[k] = we; m1_addr[k] = a; m1_wdata[k] = wd;
        end
        for (int c = 1; c <= 16 && lat == 0; c++) begin
            step();
            if (mem_en[k]) en_n++;
            if (mem_we[k]) we_n++;
            if (p == 0 ? m1_ack[k] : m0_ack[k]) oth_n++;
            if (p == 0 ? m0_ack[k] : m1_ack[k]) begin
                lat = c;
                rd  = (p == 0) ? m0_rdata[k] : m1_rdata[k];
            end
        end
        if (p == 0) m0_req[k] = 1'b0; else m1_req[k] = 1'b0;
        check($sformatf("%s.lat", tag), 32'(lat), 32'(exp_lat));
        check($sformatf("%s.en_pulses", tag), 32'(en_n), 32'd1);
        check($sformatf("%s.we_pulses", tag), 32'(we_n), {31'b0, we});
        check($sformatf("%s.other_ack", tag), 32'(oth_n), 32'd0);
        if (!we) check($sformatf("%s.rdata", tag), rd, exp_rd);
        $display("txn %s inst=%0d port=%0d we=%0d addr=0x%03h rdata=0x%08h lat=%0d",
                 tag, k, p, we, a, rd, lat);
    endtask

    initial begin
        int          lat;
        int          who;
        int          cnt;
        logic [31:0] rd;

        for (int k = 0; k < N; k++) begin
            rst[k] = 1'b1;
            m0_req[k] = 1'b0; m0_we[k] = 1'b0; m0_addr[k] = '0; m0_wdata[k] = '0;
            m1_req[k] = 1'b0; m1_we[k] = 1'b0; m1_addr[k] = '0; m1_wdata[k] = '0;
        end
        #2;
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst%0d.busy", k),   {31'b0, busy[k]},   32'd0);
            check($sformatf("rst%0d.mem_en", k), {31'b0, mem_en[k]}, 32'd0);
            check($sformatf("rst%0d.mem_we", k), {31'b0, mem_we[k]}, 32'd0);
            check($sformatf("rst%0d.grant", k),  {31'b0, grant[k]},  32'd0);
            check($sformatf("rst%0d.m0_ack", k), {31'b0, m0_ack[k]}, 32'd0);
            check($sformatf("rst%0d.m1_ack", k), {31'b0, m1_ack[k]}, 32'd0);
        end
        step();
        for (int k = 0; k < N; k++) rst[k] = 1'b0;
        step();

        // Single read, MEM_LAT=1.
        txn(0, 0, 1'b0, 10'h004, 32'h0, 32'h2008_0005, 2, "single_rd");

        // Write then read, MEM_LAT=3, requester 1.
        txn(1, 1, 1'b1, 10'h010, 32'hDEAD_BEEF, 32'h0, 4, "wr_m1");
        step();
        txn(1, 1, 1'b0, 10'h010, 32'h0, 32'hDEAD_BEEF, 4, "rd_m1");

        // Back-to-back reads on both latency variants: acks MEM_LAT+2 apart.
        step();
        for (int k = 0; k < 2; k++) begin
            txn(k, 0, 1'b0, 10'h000, 32'h0, 32'hA000_0000, LATS[k] + 1, $sformatf("b2b%0d_a0", k));
            txn(k, 0, 1'b0, 10'h001, 32'h0, 32'hA000_0001, LATS[k] + 2, $sformatf("b2b%0d_a1", k));
            txn(k, 0, 1'b0, 10'h002, 32'h0, 32'hA000_0002, LATS[k] + 2, $sformatf("b2b%0d_a2", k));
            step();
        end

        // Contention right after reset: m0 first, then strict alternation.
        #2 rst[0] = 1'b1;
        step();
        rst[0] = 1'b0;
        step();
        m0_req[0] = 1'b1; m0_we[0] = 1'b0; m0_addr[0] = 10'h004;
        m1_req[0] = 1'b1; m1_we[0] = 1'b0; m1_addr[0] = 10'h005;
        for (int n = 0; n < 4; n++) begin
            lat = 0; who = -1; cnt = 0; rd = '0;
            for (int c = 1; c <= 8 && lat == 0; c++) begin
                step();
                if (m0_ack[0] && m1_ack[0]) cnt++;
                if (m0_ack[0]) begin
                    lat = c; who = 0; rd = m0_rdata[0];
                end else if (m1_ack[0]) begin
                    lat = c; who = 1; rd = m1_rdata[0];
                end
            end
            check($sformatf("ctn%0d.winner", n), 32'(who), 32'(n % 2));
            check($sformatf("ctn%0d.grant", n), {31'b0, grant[0]}, 32'(n % 2));
            check($sformatf("ctn%0d.lat", n), 32'(lat), (n == 0) ? 32'd2 : 32'd3);
            check($sformatf("ctn%0d.both_ack", n), 32'(cnt), 32'd0);
            check($sformatf("ctn%0d.rdata", n), rd, (n % 2 == 0) ? 32'h2008_0005 : 32'hA000_0005);
            $display("txn ctn%0d inst=0 port=%0d rdata=0x%08h lat=%0d", n, who, rd, lat);
        end
        m0_req[0] = 1'b0;
        m1_req[0] = 1'b0;
        step();

        // Asynchronous reset while in WAIT, MEM_LAT=4.
        m0_req[2] = 1'b1; m0_we[2] = 1'b0; m0_addr[2] = 10'h002;
        step();
        step();
        check("arst.busy_before", {31'b0, busy[2]}, 32'd1);
        #3 rst[2] = 1'b1;
        #1;
        check("arst.busy",   {31'b0, busy[2]},   32'd0);
        check("arst.mem_en", {31'b0, mem_en[2]}, 32'd0);
        check("arst.m0_ack", {31'b0, m0_ack[2]}, 32'd0);
        check("arst.m1_ack", {31'b0, m1_ack[2]}, 32'd0);
        m0_req[2] = 1'b0;
        step();
        rst[2] = 1'b0;
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (m0_ack[2] || m1_ack[2] || mem_en[2]) cnt++;
        end
        check("arst.no_ack_after", 32'(cnt), 32'd0);
        txn(2, 0, 1'b0, 10'h002, 32'h0, 32'hA000_0002, 5, "arst_next");

        // Idle: nothing requested for 20 cycles.
        step();
        for (int c = 0; c < 20; c++) begin
            step();
            check($sformatf("idle%0d.busy", c),   {31'b0, busy[0]},   32'd0);
            check($sformatf("idle%0d.mem_en", c), {31'b0, mem_en[0]}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arb2.md
Name: mem_arb2

Overview:
- Two-requester arbiter for the single unified instruction/data memory of the multicycle CPU.
- Port m0 is the CPU memory interface (IorD-muxed address path). Port m1 is a second master, such as a program loader or a DMA/debug engine.
- Serialises accesses with round-robin fairness and handles a parameterised fixed read latency.
- Each port gets a req/ack handshake, so the CPU FSM stalls its MEM/IF state until it sees ack.

Parameters:
- ADDR_W, 10, word address width.
- DATA_W, 32, data width.
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata. Legal range 1..4.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- m0_req  in  1  CPU request; held until m0_ack.
- m0_we  in  1  CPU write enable (1 = write).
- m0_addr  in  ADDR_W  CPU word address.
- m0_wdata  in  DATA_W  CPU write data.
- m0_ack  out  1  one-cycle completion pulse to the CPU.
- m0_rdata  out  DATA_W  read data; valid only while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata: same as the m0 group, for requester 1.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data (synchronous memory).
- grant  out  1  ID of the requester currently owning memory; meaningful while busy=1.
- busy  out  1  1 whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE; all ack, mem_en, mem_we, busy = 0; grant = 0.
  - Latched addr/wdata/we registers = 0.
  - last_grant = 1, so m0 wins the first conflict.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Samples m0_req and m1_req.
  - If neither is high, stay in IDLE.
  - If exactly one is high, grant it.
  - If both are high, grant the requester != last_grant.
  - On grant: latch the winner's we, addr and wdata; set grant; set last_grant = winner; go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_en = 1; mem_we = latched we.
  - mem_addr and mem_wdata driven from the latched registers.
  - If MEM_LAT = 1, go to RESP; otherwise load the counter with MEM_LAT-2 and go to WAIT.
- WAIT:
  - mem_en = 0; mem_addr held.
  - Decrement the counter; go to RESP when the counter is 0.
- RESP (exactly one cycle):
  - ack of the granted port = 1.
  - Its rdata = mem_rdata (pass-through); the other port's ack = 0.
  - Go to IDLE unconditionally.
  - Writes also pass through RESP; their rdata is don't-care.
- Latency:
  - If req is first seen in IDLE at cycle T, ack is high at cycle T+1+MEM_LAT.
  - Minimum per-transaction occupancy is MEM_LAT+2 cycles (including the IDLE sample cycle).
- Handshake rules:
  - The requester holds req/we/addr/wdata stable until ack.
  - To issue back-to-back, it changes addr/we/wdata at the edge ending the ack cycle and keeps req high.
  - The arbiter samples the new request in the following IDLE cycle.
  - req values during ACCESS/WAIT/RESP are ignored.
- A waiting requester is granted at its next IDLE slot after the current transaction. With both requesting continuously, grants strictly alternate 0,1,0,1…
- Mid-transaction changes: a requester that drops req before ack still has its latched transaction completed and acked. Requesters must not do this.
- Reset mid-operation: immediately force IDLE with all strobes low. The in-flight transaction is dropped and no ack is produced; requesters reissue after reset.
- ack is never high on both ports in the same cycle. mem_en is high for exactly one cycle per transaction.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state encodings: IDLE=2'b00, ACCESS=2'b01, WAIT=2'b10, RESP=2'b11;
  - requester IDs: REQ_CPU=1'b0, REQ_AUX=1'b1.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker taking req[1:0] and last_grant, producing valid and winner. The FSM, latency counter and latches stay in mem_arb2.

Test Plan:
- Single read, MEM_LAT=1: m0 reads addr 0x004 with memory word 0x20080005; req seen in IDLE at T. Required: mem_en high at T+1 only, m0_ack and m0_rdata=0x20080005 at T+2, m1_ack=0 throughout.
- Write then read, MEM_LAT=3: m1 writes 0xDEADBEEF to 0x010, then reads 0x010. Required: mem_we=1 only in the write's ACCESS cycle; acks at T+4 for each transaction; read data = 0xDEADBEEF.
- Contention after reset: m0 and m1 both req at the first IDLE. Required: m0 is granted first, then m1. With both held continuously for 4 transactions, grant sequence is 0,1,0,1 and the acks never overlap.
- Back-to-back single master: m0 issues 3 reads, 0x000/0x001/0x002, updating addr each ack edge. Required: 3 acks spaced MEM_LAT+2 cycles apart with the correct data per address.
- Async reset during WAIT (MEM_LAT=4): assert rst between edges. Required: busy, mem_en and acks go to 0 immediately without a clock edge; no ack for the aborted transaction; the next request after reset completes normally.
- Idle behaviour: no requests for 20 cycles. Required: state stays IDLE, busy=0, mem_en=0 every cycle.
